// File: rtl/ctrl_pipe_ex.sv
// rtl/ctrl_pipe_ex.sv - E/M/W control pipeline with branch resolution and perf counters
module ctrl_pipe_ex #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flushE_hz,
  input  logic             validD,
  input  logic             regWriteD,
  input  logic             memWriteD,
  input  logic             ALUSrcD,
  input  logic             luiD,
  input  logic [1:0]       resultSrcD,
  input  logic [1:0]       jumpD,
  input  logic [1:0]       ALUOpD,
  input  logic [2:0]       branchD,
  input  logic             zeroE,
  input  logic             ltE,
  output logic [1:0]       ALUOpE,
  output logic             ALUSrcE,
  output logic             luiE,
  output logic [1:0]       resultSrcE,
  output logic             regWriteE,
  output logic [1:0]       pcSrcE,
  output logic             flushD,
  output logic             flushE,
  output logic             regWriteM,
  output logic             memWriteM,
  output logic [1:0]       resultSrcM,
  output logic             regWriteW,
  output logic [1:0]       resultSrcW,
  output logic [CNT_W-1:0] takenCnt,
  output logic [CNT_W-1:0] bubbleCnt,
  output logic [CNT_W-1:0] retireCnt
);

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic       alusrc;
    logic       lui;
    logic [1:0] resultsrc;
    logic [1:0] jump;
    logic [1:0] aluop;
    logic [2:0] branch;
  } ectl_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] resultsrc;
  } mctl_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] resultsrc;
  } wctl_t;

  ectl_t e_q, d_in;
  mctl_t m_q;
  wctl_t w_q;
  logic  take_b;
  logic  redirect;

  // A killed slot in D enters E as an all-zero bubble
  always_comb begin
    d_in = '0;
    if (validD) begin
      d_in.valid     = 1'b1;
      d_in.regwrite  = regWriteD;
      d_in.memwrite  = memWriteD;
      d_in.alusrc    = ALUSrcD;
      d_in.lui       = luiD;
      d_in.resultsrc = resultSrcD;
      d_in.jump      = jumpD;
      d_in.aluop     = ALUOpD;
      d_in.branch    = branchD;
    end
  end

  always_comb begin
    take_b = 1'b0;
    case (e_q.branch)
      3'b001:  take_b = zeroE;
      3'b010:  take_b = ~zeroE;
      3'b011:  take_b = ltE;
      3'b100:  take_b = ~ltE;
      default: take_b = 1'b0;
    endcase
  end

  always_comb begin
    pcSrcE = 2'b00;
    if (e_q.valid) begin
      if (e_q.jump == 2'b10)
        pcSrcE = 2'b10;
      else if (e_q.jump == 2'b01 || take_b)
        pcSrcE = 2'b01;
    end
  end

  assign redirect = (pcSrcE != 2'b00);
  assign flushD   = redirect;
  assign flushE   = flushE_hz | redirect;

  assign ALUOpE     = e_q.aluop;
  assign ALUSrcE    = e_q.alusrc;
  assign luiE       = e_q.lui;
  assign resultSrcE = e_q.resultsrc;
  assign regWriteE  = e_q.regwrite;
  assign regWriteM  = m_q.regwrite;
  assign memWriteM  = m_q.memwrite;
  assign resultSrcM = m_q.resultsrc;
  assign regWriteW  = w_q.regwrite;
  assign resultSrcW = w_q.resultsrc;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      takenCnt  <= '0;
      bubbleCnt <= '0;
      retireCnt <= '0;
    end else if (!hold) begin
      e_q <= flushE ? '0 : d_in;
      m_q <= '{valid: e_q.valid, regwrite: e_q.regwrite,
               memwrite: e_q.memwrite, resultsrc: e_q.resultsrc};
      w_q <= '{valid: m_q.valid, regwrite: m_q.regwrite,
               resultsrc: m_q.resultsrc};
      if (redirect && takenCnt != '1)
        takenCnt <= takenCnt + CNT_W'(1);
      if (flushE && validD && bubbleCnt != '1)
        bubbleCnt <= bubbleCnt + CNT_W'(1);
      if (w_q.valid && retireCnt != '1)
        retireCnt <= retireCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_ex.sv
// tb/tb_ctrl_pipe_ex.sv - scoreboard bench for ctrl_pipe_ex against an instruction-level model
module tb_ctrl_pipe_ex;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hold, flushE_hz, validD, regWriteD, memWriteD, ALUSrcD, luiD;
  logic [1:0] resultSrcD, jumpD, ALUOpD;
  logic [2:0] branchD;
  logic zeroE, ltE;
  logic [1:0] ALUOpE, resultSrcE, pcSrcE, resultSrcM, resultSrcW;
  logic ALUSrcE, luiE, regWriteE, flushD, flushE, regWriteM, memWriteM, regWriteW;
  logic [CNT_W-1:0] takenCnt, bubbleCnt, retireCnt;

  ctrl_pipe_ex #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flushE_hz(flushE_hz), .validD(validD),
    .regWriteD(regWriteD), .memWriteD(memWriteD), .ALUSrcD(ALUSrcD), .luiD(luiD),
    .resultSrcD(resultSrcD), .jumpD(jumpD), .ALUOpD(ALUOpD), .branchD(branchD),
    .zeroE(zeroE), .ltE(ltE), .ALUOpE(ALUOpE), .ALUSrcE(ALUSrcE), .luiE(luiE),
    .resultSrcE(resultSrcE), .regWriteE(regWriteE), .pcSrcE(pcSrcE), .flushD(flushD),
    .flushE(flushE), .regWriteM(regWriteM), .memWriteM(memWriteM),
    .resultSrcM(resultSrcM), .regWriteW(regWriteW), .resultSrcW(resultSrcW),
    .takenCnt(takenCnt), .bubbleCnt(bubbleCnt), .retireCnt(retireCnt)
  );

  // One instruction as the model sees it; a bubble is simply an absent instruction
  typedef struct {
    bit present;
    int rw, mw, as, lui, rs, jmp, op, br;
  } instr_t;

  typedef struct {
    bit rst, hold, hz, vd;
    int rw, mw, as, lui, rs, jmp, op, br, z, lt;
  } stim_t;

  typedef struct {
    int v[17];
  } exp_t;

  string names[17] = '{"ALUOpE", "ALUSrcE", "luiE", "resultSrcE", "regWriteE", "pcSrcE",
                       "flushD", "flushE", "regWriteM", "memWriteM", "resultSrcM",
                       "regWriteW", "resultSrcW", "takenCnt", "bubbleCnt", "retireCnt", "pad"};

  instr_t ex_i, mem_i, wb_i, none_i;
  int n_taken, n_bubble, n_retire;
  stim_t cur;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic int redirect_kind(instr_t x, int z, int lt);
    bit cond;
    if (!x.present) return 0;
    if (x.jmp == 2) return 2;
    cond = (x.br == 1 && z == 1) || (x.br == 2 && z == 0) ||
           (x.br == 3 && lt == 1) || (x.br == 4 && lt == 0);
    return (x.jmp == 1 || cond) ? 1 : 0;
  endfunction

  function automatic int sat(int c);
    return (c < CMAX) ? c + 1 : CMAX;
  endfunction

  task automatic model_edge();
    int kind;
    bit killed;
    instr_t d;
    if (cur.rst) begin
      ex_i = none_i; mem_i = none_i; wb_i = none_i;
      n_taken = 0; n_bubble = 0; n_retire = 0;
    end else if (!cur.hold) begin
      kind = redirect_kind(ex_i, cur.z, cur.lt);
      killed = cur.hz || kind != 0;
      if (kind != 0) n_taken = sat(n_taken);
      if (killed && cur.vd) n_bubble = sat(n_bubble);
      if (wb_i.present) n_retire = sat(n_retire);
      d = '{1'b1, cur.rw, cur.mw, cur.as, cur.lui, cur.rs, cur.jmp, cur.op, cur.br};
      wb_i = mem_i;
      mem_i = ex_i;
      ex_i = (killed || !cur.vd) ? none_i : d;
    end
  endtask

  function automatic exp_t expected();
    exp_t x;
    int kind;
    kind = redirect_kind(ex_i, cur.z, cur.lt);
    x.v[0] = ex_i.op;   x.v[1] = ex_i.as;   x.v[2] = ex_i.lui;
    x.v[3] = ex_i.rs;   x.v[4] = ex_i.rw;   x.v[5] = kind;
    x.v[6] = (kind != 0) ? 1 : 0;
    x.v[7] = (cur.hz || kind != 0) ? 1 : 0;
    x.v[8] = mem_i.rw;  x.v[9] = mem_i.mw;  x.v[10] = mem_i.rs;
    x.v[11] = wb_i.rw;  x.v[12] = wb_i.rs;
    x.v[13] = n_taken;  x.v[14] = n_bubble; x.v[15] = n_retire;
    x.v[16] = 0;
    return x;
  endfunction

  task automatic drive(stim_t s);
    cur = s;
    rst = s.rst; hold = s.hold; flushE_hz = s.hz; validD = s.vd;
    regWriteD = 1'(s.rw); memWriteD = 1'(s.mw); ALUSrcD = 1'(s.as); luiD = 1'(s.lui);
    resultSrcD = 2'(s.rs); jumpD = 2'(s.jmp); ALUOpD = 2'(s.op); branchD = 3'(s.br);
    zeroE = 1'(s.z); ltE = 1'(s.lt);
  endtask

  // Advance one clock: the model consumes the inputs present at this edge, then next inputs apply
  task automatic step(stim_t s);
    @(posedge clk);
    model_edge();
    #1;
    drive(s);
    exp_q.push_back(expected());
  endtask

  function automatic stim_t mk(bit r, bit h, bit hz, bit vd, int rw, int mw, int rs,
                               int jmp, int br, int z, int lt);
    stim_t s;
    s = '{r, h, hz, vd, rw, mw, 0, 0, rs, jmp, 0, br, z, lt};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(99) < 2);
    s.hold = ($urandom_range(99) < 12);
    s.hz = ($urandom_range(99) < 15);
    s.vd = ($urandom_range(99) < 85);
    s.rw = $urandom_range(1); s.mw = $urandom_range(1);
    s.as = $urandom_range(1); s.lui = $urandom_range(1);
    s.rs = $urandom_range(3); s.jmp = $urandom_range(3);
    s.op = $urandom_range(3); s.br = $urandom_range(7);
    s.z = $urandom_range(1); s.lt = $urandom_range(1);
    return s;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int act[17];
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = '{int'(ALUOpE), int'(ALUSrcE), int'(luiE), int'(resultSrcE), int'(regWriteE),
              int'(pcSrcE), int'(flushD), int'(flushE), int'(regWriteM), int'(memWriteM),
              int'(resultSrcM), int'(regWriteW), int'(resultSrcW), int'(takenCnt),
              int'(bubbleCnt), int'(retireCnt), 0};
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (act[i] != e.v[i]) begin
          failures++;
          $display("FAIL %s at %0t: got %0d expected %0d", names[i], $time, act[i], e.v[i]);
        end
      end
    end
  end

  initial begin
    none_i = '{1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
    ex_i = none_i; mem_i = none_i; wb_i = none_i;
    n_taken = 0; n_bubble = 0; n_retire = 0;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // straight-line addi stream
    for (int i = 0; i < 5; i++) step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    // BEQ taken, then BNE/BLT/BGE with the flag that decides each
    step(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0));
    step(mk(0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 0));
    step(mk(0, 0, 0, 1, 0, 0, 0, 0, 4, 0, 1));
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    // JALR writing PC+4, then filler
    step(mk(0, 0, 0, 1, 1, 0, 2, 2, 0, 0, 0));
    for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    // lw, then load-use bubble requested while held, then released
    step(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
    step(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    // JAL stream to push every counter into saturation, then reset mid-stream
    for (int i = 0; i < 40; i++) step(mk(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
    step(mk(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 800; i++) step(rnd());
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
